key_event_ctrl: RTL and testbench
=================================

Name: key_event_ctrl

Overview:
Event controller placed after a bank of per-key debouncers in the LED design. It classifies each debounced key level into SHORT, LONG and REPEAT press events using per-key timers. Simultaneous events are arbitrated round-robin into one small event FIFO. The LED mode logic drains that FIFO through a valid/ready handshake.

Parameters:
NUM_KEYS, 4, number of debounced key inputs (1..8)
LONG_CYCLES, 50_000_000, press duration that yields a LONG event (1 s at 50 MHz)
REPEAT_CYCLES, 10_000_000, interval between REPEAT events while the key stays held after LONG
FIFO_DEPTH, 4, event FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
key_db  in  NUM_KEYS  debounced key levels, 1 = pressed, synchronous to clk
evt_ready  in  1  consumer accepts the head event when high with evt_valid
evt_valid  out  1  FIFO non-empty
evt_key  out  $clog2(NUM_KEYS) (min 1)  key index of head event
evt_type  out  2  01 SHORT, 10 LONG, 11 REPEAT (00 never output)
ovf  out  1  sticky: a pending event was overwritten; cleared only by rst

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, asynchronous and active-high. Every register clears immediately on rst assertion: all per-key FSMs to IDLE, counters 0, pending flags 0, FIFO pointers 0, RR pointer 0, evt_valid 0, evt_key 0, evt_type 0, ovf 0.
- Mid-operation reset: reset while a key is held drops any press in progress. If the key is still high after rst deasserts, treat it as a new press from IDLE.
- Per-key FSM and counter, one per key; counter is 26 bits, wide enough for max(LONG_CYCLES, REPEAT_CYCLES).
  - IDLE: key_db=1 -> PRESS, cnt<=0.
  - PRESS: key_db=0 -> emit SHORT, go to IDLE. Otherwise, if cnt==LONG_CYCLES-1 -> emit LONG, go to HELD, cnt<=0. Otherwise cnt++.
  - HELD: key_db=0 -> IDLE with no event. Otherwise, if cnt==REPEAT_CYCLES-1 -> emit REPEAT, cnt<=0. Otherwise cnt++.
  - Release and timeout in the same cycle in PRESS: release wins, so SHORT is emitted.
- Emitted events go to a per-key pending register holding a valid bit and a 2-bit type.
  - Pending is set on the same edge as the FSM transition.
  - If pending is already valid and is not being drained that cycle, the new type overwrites it and ovf<=1.
- Arbiter: round-robin over pending keys.
  - Search starts at the RR pointer. The granted key's pending entry is written into the FIFO on the next edge.
  - The pending valid bit clears on that edge, and the RR pointer moves to granted+1 (mod NUM_KEYS).
  - At most one FIFO write per cycle.
  - No grant while the FIFO is full. Pending entries wait and are never dropped for lack of FIFO space.
  - A grant is allowed when the FIFO is full and a pop happens in the same cycle.
- FIFO: FIFO_DEPTH entries of {key, type}. Output is registered-free: evt_key and evt_type show the head entry directly, and evt_valid = (count != 0).
  - Pop occurs when evt_valid && evt_ready.
  - Simultaneous push and pop keep the count unchanged.
  - Push on empty with no pop: evt_valid goes high on the following cycle.
- Latency: the key_db change is sampled at edge N. Pending is set at N, the FIFO is written at N+1, and evt_valid is high after edge N+1 (2 cycles from the sampled transition to visible event, FIFO empty, no contention).
- evt_key and evt_type hold their values while evt_valid=1 and evt_ready=0.
- Keys are fully independent. Any number of keys may be in any state concurrently.

Test Plan:
Bench params for all scenarios: NUM_KEYS=4, LONG_CYCLES=10, REPEAT_CYCLES=4, FIFO_DEPTH=2.
1. Short press: key_db[1] high for 5 cycles then low, evt_ready=1 -> exactly one event {key=1, type=01}, evt_valid high for 1 cycle, 2 cycles after the falling sample.
2. Long press with repeat: key_db[2] high for 25 cycles -> {2,10} at press+10, then {2,11} every 4 cycles (3 REPEATs total), no event on release.
3. Boundary: key held for exactly 10 cycles, releasing on the cycle cnt==9 -> SHORT only. Held for 11 cycles -> LONG only.
4. Contention: keys 0, 1 and 3 released in the same cycle after short presses, evt_ready=1, RR pointer 0 -> events appear in the order 0, 1, 3 on consecutive cycles, RR pointer ends at 0.
5. Backpressure and ovf: evt_ready=0, four short presses on key 0 spaced 3 cycles apart -> FIFO holds 2 events, the pending entry is overwritten once and ovf=1. With evt_ready=1, exactly 3 events drain, and ovf stays 1.
6. Reset mid-press: assert rst for 2 cycles at cnt=6 of a key-3 press with FIFO non-empty -> evt_valid=0 immediately. After release of rst with the key still high, LONG arrives 10 cycles later.

Source files
------------

// File: rtl/key_event_ctrl.sv
// Classifies debounced key levels into SHORT/LONG/REPEAT events and queues them round-robin into a small FIFO.
// Two cycles from sampled key edge to visible event; pending entries wait (never dropped) while the FIFO is full.
module key_event_ctrl #(
  parameter int NUM_KEYS      = 4,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int FIFO_DEPTH    = 4,
  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_db,
  input  logic                evt_ready,
  output logic                evt_valid,
  output logic [KW-1:0]       evt_key,
  output logic [1:0]          evt_type,
  output logic                ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRESS = 2'd1;
  localparam logic [1:0] HELD  = 2'd2;
  localparam logic [1:0] TYP_SHORT  = 2'b01;
  localparam logic [1:0] TYP_LONG   = 2'b10;
  localparam logic [1:0] TYP_REPEAT = 2'b11;
  localparam logic [25:0] LONG_LAST = 26'(LONG_CYCLES - 1);
  localparam logic [25:0] REP_LAST  = 26'(REPEAT_CYCLES - 1);

  logic [1:0]          state    [NUM_KEYS];
  logic [25:0]         cnt      [NUM_KEYS];
  logic [NUM_KEYS-1:0] emit;
  logic [1:0]          emit_typ [NUM_KEYS];
  logic [NUM_KEYS-1:0] pend_vld;
  logic [1:0]          pend_typ [NUM_KEYS];
  logic [KW-1:0]       rr_ptr;
  logic                grant_vld;
  logic [KW-1:0]       grant_key;
  logic [KW-1:0]       mem_key  [FIFO_DEPTH];
  logic [1:0]          mem_typ  [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                fifo_full, pop, push;

  // Release in PRESS takes priority over the LONG timeout.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      emit[k]     = 1'b0;
      emit_typ[k] = 2'b00;
      case (state[k])
        PRESS: begin
          if (!key_db[k]) begin
            emit[k] = 1'b1; emit_typ[k] = TYP_SHORT;
          end else if (cnt[k] == LONG_LAST) begin
            emit[k] = 1'b1; emit_typ[k] = TYP_LONG;
          end
        end
        HELD: begin
          if (key_db[k] && cnt[k] == REP_LAST) begin
            emit[k] = 1'b1; emit_typ[k] = TYP_REPEAT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        state[k] <= IDLE;
        cnt[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        case (state[k])
          IDLE: if (key_db[k]) begin state[k] <= PRESS; cnt[k] <= '0; end
          PRESS: begin
            if (!key_db[k])              state[k] <= IDLE;
            else if (cnt[k] == LONG_LAST) begin state[k] <= HELD; cnt[k] <= '0; end
            else                         cnt[k] <= cnt[k] + 26'd1;
          end
          HELD: begin
            if (!key_db[k])              state[k] <= IDLE;
            else if (cnt[k] == REP_LAST) cnt[k] <= '0;
            else                         cnt[k] <= cnt[k] + 26'd1;
          end
          default: state[k] <= IDLE;
        endcase
      end
    end
  end

  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;
  assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
  assign push      = grant_vld;

  // Scan offsets from high to low so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_key = '0;
    idx       = 0;
    if (!fifo_full || pop) begin
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
        idx = int'(rr_ptr) + i;
        if (idx >= NUM_KEYS) idx = idx - NUM_KEYS;
        if (pend_vld[idx]) begin
          grant_vld = 1'b1;
          grant_key = KW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld <= '0;
      ovf      <= 1'b0;
      rr_ptr   <= '0;
      for (int k = 0; k < NUM_KEYS; k++) pend_typ[k] <= 2'b00;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (emit[k]) begin
          pend_vld[k] <= 1'b1;
          pend_typ[k] <= emit_typ[k];
          if (pend_vld[k] && !(grant_vld && grant_key == KW'(k))) ovf <= 1'b1;
        end else if (grant_vld && grant_key == KW'(k)) begin
          pend_vld[k] <= 1'b0;
        end
      end
      if (grant_vld)
        rr_ptr <= (int'(grant_key) == NUM_KEYS - 1) ? '0 : grant_key + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_key[i] <= '0;
        mem_typ[i] <= 2'b00;
      end
    end else begin
      if (push) begin
        mem_key[wr_ptr] <= grant_key;
        mem_typ[wr_ptr] <= pend_typ[grant_key];
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Gate the head so an empty FIFO never shows a stale entry.
  assign evt_key  = evt_valid ? mem_key[rd_ptr] : '0;
  assign evt_type = evt_valid ? mem_typ[rd_ptr] : 2'b00;
endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: table of single-key presses plus contention, backpressure and reset sequences.
module tb_key_event_ctrl;
  localparam int NK = 4;
  localparam int LC = 10;
  localparam int RC = 4;
  localparam int FD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_db = '0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [1:0] evt_key;
  logic [1:0] evt_type;
  logic       ovf;

  key_event_ctrl #(
    .NUM_KEYS(NK), .LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .key_db(key_db), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_key(evt_key), .evt_type(evt_type), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         key;
    int         typ;
    int         at;   // expected visible cycle, -1 = untimed
  } exp_t;
  exp_t q[$];

  typedef struct {
    int         key;
    int         hold;
    logic [1:0] first_typ;
    int         n_rep;
  } vec_t;
  vec_t vecs[6];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int k, input int t, input int at);
    exp_t e;
    e.key = k; e.typ = t; e.at = at;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Scoreboard: every accepted event must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_evt: got key=%0d type=%0d, expected none (cycle %0d)", evt_key, evt_type, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("evt_key", int'(evt_key), e.key);
        check("evt_type", int'(evt_type), e.typ);
        if (e.at >= 0) check("evt_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end by 200000");
    $fatal(1);
  end

  initial begin
    int p;
    vecs[0] = '{1,  5, 2'b01, 0};
    vecs[1] = '{2, 25, 2'b10, 3};
    vecs[2] = '{0, 10, 2'b01, 0};
    vecs[3] = '{3, 11, 2'b10, 0};
    vecs[4] = '{1, 14, 2'b10, 0};
    vecs[5] = '{2, 15, 2'b10, 1};

    #1 rst = 1'b1;
    tick(2);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_key",   int'(evt_key),   0);
    check("rst_type",  int'(evt_type),  0);
    check("rst_ovf",   int'(ovf),       0);
    rst = 1'b0;
    tick(1);

    // Single-key presses, consumer always ready.
    for (int v = 0; v < 6; v++) begin
      p = cyc + 1;
      if (vecs[v].first_typ == 2'b01) begin
        push_exp(vecs[v].key, 1, p + vecs[v].hold + 1);
      end else begin
        push_exp(vecs[v].key, 2, p + LC + 1);
        for (int r = 1; r <= vecs[v].n_rep; r++)
          push_exp(vecs[v].key, 3, p + LC + RC * r + 1);
      end
      key_db[vecs[v].key] = 1'b1;
      tick(vecs[v].hold);
      key_db[vecs[v].key] = 1'b0;
      tick(4);
      check("table_drained", q.size(), 0);
      check("table_idle_valid", int'(evt_valid), 0);
    end

    // Contention: keys 0, 1, 3 released together with rr_ptr at 0.
    do_reset();
    p = cyc + 1;
    push_exp(0, 1, p + 3 + 1);
    push_exp(1, 1, p + 3 + 2);
    push_exp(3, 1, p + 3 + 3);
    key_db = 4'b1011;
    tick(3);
    key_db = 4'b0000;
    tick(6);
    check("rr_drained", q.size(), 0);
    check("rr_ptr_end", int'(dut.rr_ptr), 0);

    // Backpressure: four short presses on key 0, fourth overwrites the pending third.
    do_reset();
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      key_db[0] = 1'b1; tick(1); key_db[0] = 1'b0; tick(2);
    end
    check("bp_ovf_before", int'(ovf), 0);
    check("bp_valid_held", int'(evt_valid), 1);
    check("bp_key_held",   int'(evt_key),   0);
    check("bp_type_held",  int'(evt_type),  1);
    key_db[0] = 1'b1; tick(1); key_db[0] = 1'b0; tick(2);
    check("bp_ovf_after", int'(ovf), 1);
    for (int i = 0; i < 3; i++) push_exp(0, 1, -1);
    evt_ready = 1'b1;
    tick(6);
    check("bp_drained", q.size(), 0);
    check("bp_empty", int'(evt_valid), 0);
    check("bp_ovf_sticky", int'(ovf), 1);

    // Reset at cnt=6 of a key-3 press with the FIFO holding an event.
    do_reset();
    evt_ready = 1'b0;
    key_db[0] = 1'b1; tick(1); key_db[0] = 1'b0; tick(3);
    check("mr_fifo_nonempty", int'(evt_valid), 1);
    key_db[3] = 1'b1;
    tick(7);
    #2 rst = 1'b1;
    #1;
    check("mr_valid_async", int'(evt_valid), 0);
    check("mr_type_async",  int'(evt_type),  0);
    check("mr_ovf_async",   int'(ovf),       0);
    tick(2);
    rst = 1'b0;
    evt_ready = 1'b1;
    p = cyc + 1;
    push_exp(3, 2, p + LC + 1);
    tick(12);
    key_db[3] = 1'b0;
    tick(4);
    check("mr_drained", q.size(), 0);
    check("mr_idle_valid", int'(evt_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
